// File: rtl/wave_trace_render.sv
// Renders a captured waveform into the x 512..1023, y 0..511 window of a 1280x1024 scan, three cycles behind x/y.
// Optional build macro WAVE_GRID_EN overlays a grid on non-trace pixels inside the window.
module wave_trace_render #(
  parameter logic [23:0] TRACE_RGB = 24'hFFFFFF,
  parameter logic [23:0] GRID_RGB  = 24'h404040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        wave_display_idle,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } state_t;

  // Per-pixel context carried alongside the RAM access latency.
  typedef struct packed {
    logic        valid;
    logic        region;
    logic [10:0] x;
    logic [7:0]  row;
`ifdef WAVE_GRID_EN
    logic        grid_y;
`endif
  } stage_t;

  localparam int          PRE_STAGES  = 2;
  localparam logic [10:0] ROW_START_X = 11'd512;

  state_t      state_q, state_d;
  logic        idle_q, idle_d;
  logic        frame_half_q, frame_half_d;
  logic [8:0]  read_address_q, read_address_d;
  logic [7:0]  cur_sample_q, cur_sample_d;
  logic [7:0]  prev_sample_q, prev_sample_d;
  logic        valid_pixel_q, valid_pixel_d;
  logic [23:0] rgb_q, rgb_d;

  stage_t      stage_q [PRE_STAGES];
  stage_t      in_stage;
  stage_t      s2;

  logic        in_region;
  logic        frame_start;
  logic [7:0]  plot_cur, plot_prev, plot_lo, plot_hi;
  logic        trace_hit;
  logic        grid_hit;

  assign in_region   = valid && (x[10:9] == 2'b01) && !y[9];
  assign frame_start = valid && (x == 11'd0) && (y == 10'd0);
  assign s2          = stage_q[PRE_STAGES-1];

  always_comb begin
    in_stage        = '0;
    in_stage.valid  = valid;
    in_stage.region = in_region;
    in_stage.x      = x;
    in_stage.row    = y[8:1];
`ifdef WAVE_GRID_EN
    in_stage.grid_y = (y[5:0] == 6'd0);
`endif
  end

  // The displayed half is latched once per frame so capture can refill the other half freely.
  always_comb begin
    frame_half_d   = frame_half_q;
    read_address_d = read_address_q;
    if (frame_start) begin
      frame_half_d = read_index;
    end
    if (in_region) begin
      read_address_d = {~frame_half_q, x[8:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (valid && y[9]) state_d = BLANK;
      BLANK:   if (frame_start)   state_d = SCAN;
      default: state_d = BLANK;
    endcase
    idle_d = (state_d == BLANK);
  end

  // Each sample spans two columns; a new address shifts the old sample into prev.
  always_comb begin
    cur_sample_d  = cur_sample_q;
    prev_sample_d = prev_sample_q;
    if (s2.valid && s2.region) begin
      cur_sample_d = read_value;
      if (s2.x == ROW_START_X) begin
        prev_sample_d = read_value;
      end else if (!s2.x[0]) begin
        prev_sample_d = cur_sample_q;
      end
    end
  end

  always_comb begin
    plot_cur  = 8'd255 - cur_sample_d;
    plot_prev = 8'd255 - prev_sample_d;
    if (plot_cur < plot_prev) begin
      plot_lo = plot_cur;
      plot_hi = plot_prev;
    end else begin
      plot_lo = plot_prev;
      plot_hi = plot_cur;
    end
    trace_hit = (s2.row >= plot_lo) && (s2.row <= plot_hi);
  end

`ifdef WAVE_GRID_EN
  assign grid_hit = (s2.x[5:0] == 6'd0) || s2.grid_y;
`else
  assign grid_hit = 1'b0;
`endif

  always_comb begin
    valid_pixel_d = s2.valid;
    rgb_d         = 24'h000000;
    if (s2.valid && s2.region) begin
      if (trace_hit) begin
        rgb_d = TRACE_RGB;
      end else if (grid_hit) begin
        rgb_d = GRID_RGB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= BLANK;
      idle_q         <= 1'b1;
      frame_half_q   <= 1'b0;
      read_address_q <= 9'd0;
      cur_sample_q   <= 8'd0;
      prev_sample_q  <= 8'd0;
      valid_pixel_q  <= 1'b0;
      rgb_q          <= 24'h000000;
      for (int i = 0; i < PRE_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idle_q         <= idle_d;
      frame_half_q   <= frame_half_d;
      read_address_q <= read_address_d;
      cur_sample_q   <= cur_sample_d;
      prev_sample_q  <= prev_sample_d;
      valid_pixel_q  <= valid_pixel_d;
      rgb_q          <= rgb_d;
      stage_q[0]     <= in_stage;
      for (int i = 1; i < PRE_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign read_address      = read_address_q;
  assign wave_display_idle = idle_q;
  assign valid_pixel       = valid_pixel_q;
  assign r                 = rgb_q[23:16];
  assign g                 = rgb_q[15:8];
  assign b                 = rgb_q[7:0];

endmodule

// File: tb/tb_wave_trace_render.sv
// Scoreboard bench for wave_trace_render: expected pixels are computed from the bench's sample RAM
// and compared three cycles later; read address and idle flag are checked directly.
module tb_wave_trace_render;

  localparam logic [23:0] TRACE = 24'h12C0F3;
  localparam logic [23:0] GRID  = 24'h404040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0;
  logic        read_index = 1'b0;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        wave_display_idle;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  logic [7:0]  ram [512];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic       half_m = 1'b0;
  logic [8:0] addr_m = '0;

  typedef struct {
    int          due;
    int          px;
    int          py;
    logic [24:0] exp;
  } exp_t;
  exp_t q[$];

  wave_trace_render #(
    .TRACE_RGB(TRACE),
    .GRID_RGB (GRID)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .x                (x),
    .y                (y),
    .valid            (valid),
    .read_index       (read_index),
    .read_value       (read_value),
    .read_address     (read_address),
    .wave_display_idle(wave_display_idle),
    .valid_pixel      (valid_pixel),
    .r                (r),
    .g                (g),
    .b                (b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) read_value <= ram[read_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected {valid_pixel, rgb} assuming each region row is scanned contiguously from x=512.
  function automatic logic [24:0] model(logic [10:0] xv, logic [9:0] yv, logic v, logic half);
    logic [7:0] a, cur, prev, pc, pp, lo, hi;
    if (!v) return 25'd0;
    if (!(xv[10:9] == 2'b01 && !yv[9])) return {1'b1, 24'h0};
    a    = xv[8:1];
    cur  = ram[{~half, a}];
    prev = (a == 8'd0) ? cur : ram[{~half, a - 8'd1}];
    pc   = 8'd255 - cur;
    pp   = 8'd255 - prev;
    lo   = (pc < pp) ? pc : pp;
    hi   = (pc < pp) ? pp : pc;
    if (yv[8:1] >= lo && yv[8:1] <= hi) return {1'b1, TRACE};
`ifdef WAVE_GRID_EN
    if (xv[5:0] == 6'd0 || yv[5:0] == 6'd0) return {1'b1, GRID};
`endif
    return {1'b1, 24'h0};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("pixel x=%0d y=%0d", e.px, e.py), {7'd0, valid_pixel, r, g, b}, {7'd0, e.exp});
    end
  end

  task automatic drive(input int xx, input int yy, input logic v, input logic ri);
    logic [10:0] xv;
    logic [9:0]  yv;
    exp_t        e;
    @(posedge clk);
    #1;
    check("read_address", {23'd0, read_address}, {23'd0, addr_m});
    xv = 11'(xx);
    yv = 10'(yy);
    x = xv;
    y = yv;
    valid = v;
    read_index = ri;
    if (v && xv == 11'd0 && yv == 10'd0) half_m = ri;
    if (v && xv[10:9] == 2'b01 && !yv[9]) addr_m = {~half_m, xv[8:1]};
    e.due = cyc + 3;
    e.px  = xx;
    e.py  = yy;
    e.exp = model(xv, yv, v, half_m);
    q.push_back(e);
  endtask

  task automatic drive_row(input int yy, input int x0, input int x1, input logic ri);
    for (int i = x0; i <= x1; i++) drive(i, yy, 1'b1, ri);
  endtask

  task automatic drain(input logic ri);
    repeat (4) drive(0, 0, 1'b0, ri);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    half_m = 1'b0;
    addr_m = '0;
    check("rst valid_pixel", {31'd0, valid_pixel}, 32'd0);
    check("rst rgb", {8'd0, r, g, b}, 32'd0);
    check("rst idle", {31'd0, wave_display_idle}, 32'd1);
    check("rst read_address", {23'd0, read_address}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'd128;
    for (int i = 256; i < 512; i++) ram[i] = 8'd40;
    do_reset();

    // Frame start with read_index=1: lower half displayed, scan leaves BLANK.
    drive(0, 0, 1'b1, 1'b1);
    drive(1, 0, 1'b1, 1'b1);
    drive(2, 0, 1'b1, 1'b1);
    check("idle after frame start", {31'd0, wave_display_idle}, 32'd0);
    check("read_address msb", {31'd0, read_address[8]}, 32'd0);

    // Flat trace at 128: row 254 fully lit, rows 252 and 256 dark.
    drive_row(254, 512, 1023, 1'b1);
    drive_row(252, 512, 1023, 1'b1);
    drive_row(256, 512, 1023, 1'b1);
    drain(1'b1);

    // Step 255 -> 0 between addresses 10 and 11: full-height connector at x=534.
    for (int i = 0; i < 256; i++) ram[i] = (i <= 10) ? 8'd255 : 8'd0;
    for (int yy = 0; yy < 256; yy++) drive_row(yy * 2, 512, 535, 1'b1);
    drain(1'b1);

    // read_index flips mid-frame; the displayed half must not follow.
    drive(0, 100, 1'b1, 1'b0);
    drive_row(100, 512, 520, 1'b0);
    drive(521, 100, 1'b1, 1'b0);
    check("half held mid-frame", {31'd0, read_address[8]}, 32'd0);
    drain(1'b0);

    // Flat trace at 0 sits on rows 510/511; grid lines (if built) elsewhere.
    for (int i = 0; i < 256; i++) ram[i] = 8'd0;
    drive_row(64, 512, 580, 1'b0);
    drive_row(510, 512, 580, 1'b0);
    drain(1'b0);

    // Leaving the wave area raises idle until the next frame start.
    check("idle before y=512", {31'd0, wave_display_idle}, 32'd0);
    drive(0, 512, 1'b1, 1'b0);
    drive(1, 512, 1'b1, 1'b0);
    drive(2, 512, 1'b1, 1'b0);
    check("idle at y=512", {31'd0, wave_display_idle}, 32'd1);
    drive_row(700, 0, 5, 1'b0);
    drive_row(1023, 1270, 1279, 1'b0);
    check("idle held in blank", {31'd0, wave_display_idle}, 32'd1);
    drive(0, 0, 1'b1, 1'b0);
    drive(1, 0, 1'b1, 1'b0);
    drive(2, 0, 1'b1, 1'b0);
    check("idle after next frame", {31'd0, wave_display_idle}, 32'd0);

    // Upper half now displayed (sample 40 -> plot row 215).
    drive_row(430, 512, 600, 1'b0);
    drive_row(432, 512, 600, 1'b0);
    drain(1'b0);

    // Reset in the middle of a row drops in-flight pixels.
    drive_row(20, 512, 520, 1'b0);
    do_reset();
    drain(1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wave_trace_render.md
WAVE_TRACE_RENDER -- requirements
Module: wave_trace_render

Interface
REQ-001 Parameter TRACE_RGB, default 24'hFFFFFF, colour of waveform pixels.
REQ-002 Parameter GRID_RGB, default 24'h404040, colour of grid pixels (used only when WAVE_GRID_EN is defined).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 x  input  11  VGA column of current pixel, 0..1279.
REQ-006 y  input  10  VGA row of current pixel, 0..1023.
REQ-007 valid  input  1  x/y describe a visible pixel this cycle.
REQ-008 read_index  input  1  half of sample RAM currently being written by wave_capture.
REQ-009 read_value  input  8  sample RAM data; synchronous RAM, valid one cycle after read_address.
REQ-010 read_address  output  9  sample RAM read address.
REQ-011 wave_display_idle  output  1  high while the scan is outside the wave region; feeds wave_capture.
REQ-012 valid_pixel  output  1  r/g/b valid for the pixel presented 3 cycles earlier.
REQ-013 r, g, b  output  8 each  pixel colour.

Function
REQ-014 Wave region: valid high, x[10:9]==2'b01 (x 512..1023), y[9]==0 (y 0..511); all other pixels are background (r/g/b 0).
REQ-015 frame_half register loads read_index when valid, x==0, y==0; it never changes at any other time, so the displayed half is fixed for the whole frame.
REQ-016 read_address is registered: at the edge after input cycle N, read_address = {~frame_half, x[8:1]}; it updates only when the pixel is in the wave region.
REQ-017 x, y, valid and region flag pass through a 3-stage pipeline; valid_pixel and r/g/b appear exactly 3 cycles after the corresponding input (latency 3).
REQ-018 cur_sample loads read_value in stage 2; when stage-2 x[0]==0 (new address), prev_sample loads the old cur_sample first.
REQ-019 At the first wave-region pixel of each row (x==512), prev_sample loads the same value as cur_sample, so no vertical streak carries over between rows.
REQ-020 Plot value p = 8'd255 - sample (high sample at top); hit when y[8:1] lies between p(prev_sample) and p(cur_sample), inclusive, in either order.
REQ-021 Hit pixel in region -> {r,g,b} = TRACE_RGB; non-hit -> 0 (or grid per REQ-026).
REQ-022 State machine, 2 states: SCAN (current row inside y 0..511) and BLANK (y 512..1023); SCAN->BLANK on a valid pixel with y[9]==1; BLANK->SCAN on a valid pixel with x==0, y==0.
REQ-023 wave_display_idle is registered, high in BLANK, low in SCAN; it changes one cycle after the transitioning pixel.
REQ-024 Pixels with valid low do not change state, frame_half, or sample registers; pipeline still advances and emits valid_pixel 0.

Reset
REQ-025 On reset: state BLANK, wave_display_idle 1, frame_half 0, read_address 0, cur_sample and prev_sample 0, pipeline valid stages 0, valid_pixel 0, r/g/b 0; reset mid-frame discards all in-flight pixels.

Configuration
REQ-026 Macro WAVE_GRID_EN: when defined, non-hit region pixels with x[5:0]==0 or y[5:0]==0 output GRID_RGB (trace overrides grid); when undefined, no grid logic exists and non-hit pixels are 0.

Verification
REQ-027 Reset, then x=0,y=0,valid with read_index=1 -> next cycle read_address[8]=0, state SCAN, wave_display_idle 0 one cycle later.
REQ-028 Constant RAM value 8'd128 across row y=254 -> valid_pixel 1 with TRACE_RGB for every x 512..1023 three cycles later; rows 252 and 256 all black.
REQ-029 RAM step from 8'd255 to 8'd0 between addresses 10 and 11 -> on stage for x=534 column pixels with y[8:1] 0..255 all TRACE_RGB (vertical connector).
REQ-030 Toggle read_index mid-frame at y=100 -> read_address[8] unchanged until next x=0,y=0 pixel.
REQ-031 Scan reaches y=512 -> wave_display_idle rises one cycle later and stays high until after x=0,y=0 of next frame.
REQ-032 With WAVE_GRID_EN, flat trace at 8'd0 -> pixel x=576,y=64 GRID_RGB, pixel x=576,y=510 TRACE_RGB; without macro x=576,y=64 is 0.
